// File: rtl/plane_hit_ctrl.sv
// plane_hit_ctrl: per-frame player collision commit, explosion hold, lives, invulnerability and game over
// Ports: clk/rst (async active-high); clk_move movement clock (synchronized here);
//   x/y current pixel; myplane_en/enemy_en/ebullet_en sprite pixel enables; myplane_exist plane present;
//   restart new-game pulse; boom/invuln/game_over registered state decodes; lives remaining; hit_pulse per committed hit.
module plane_hit_ctrl #(
  parameter int LIVES        = 3,
  parameter int BOOM_HOLD    = 32,
  parameter int INVULN_TICKS = 64,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_move,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       myplane_en,
  input  logic       enemy_en,
  input  logic       ebullet_en,
  input  logic       myplane_exist,
  input  logic       restart,
  output logic       boom,
  output logic       invuln,
  output logic [2:0] lives,
  output logic       game_over,
  output logic       hit_pulse
);
  typedef enum logic [1:0] {ALIVE, BOOM, INVULN, OVER} state_t;
  state_t     state_q, state_d;
  logic [2:0] sync_q, sync_d;
  logic [9:0] px_q, py_q;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0] lives_q, lives_d;
  logic       pending_q, pending_d;
  logic       boom_q, boom_d, invuln_q, invuln_d, over_q, over_d, hit_q;
  logic       tick, overlap, frame_end, hit;
  always_comb begin
    sync_d    = {sync_q[1:0], clk_move};
    tick      = sync_q[1] & ~sync_q[2];
    overlap   = myplane_en & (enemy_en | ebullet_en) & (x < 10'(H_ACTIVE)) & (y < 10'(V_ACTIVE));
    // compare with the previous pixel so a held corner pixel yields a single pulse
    frame_end = (x == 10'(H_ACTIVE - 1)) && (y == 10'(V_ACTIVE - 1)) &&
                !((px_q == 10'(H_ACTIVE - 1)) && (py_q == 10'(V_ACTIVE - 1)));
    hit       = (state_q == ALIVE) && frame_end && (pending_q || overlap) && myplane_exist;
    // collisions only accumulate while vulnerable, so overlap seen during immunity never leaks into ALIVE
    pending_d = frame_end ? 1'b0 : pending_q | (overlap & (state_q == ALIVE));
    cnt_inc   = cnt_q + 8'd1;
    state_d   = state_q;
    cnt_d     = cnt_q;
    lives_d   = lives_q;
    case (state_q)
      ALIVE: if (hit) begin
        lives_d = lives_q - 3'd1;
        cnt_d   = 8'd0;
        state_d = BOOM;
      end
      BOOM: if (tick) begin
        cnt_d = cnt_inc;
        if (cnt_inc == 8'(BOOM_HOLD)) begin
          cnt_d   = 8'd0;
          state_d = (lives_q == 3'd0) ? OVER : INVULN;
        end
      end
      INVULN: if (tick) begin
        cnt_d = cnt_inc;
        if (cnt_inc == 8'(INVULN_TICKS)) begin
          cnt_d   = 8'd0;
          state_d = ALIVE;
        end
      end
      OVER: if (restart) begin
        lives_d = 3'(LIVES);
        cnt_d   = 8'd0;
        state_d = ALIVE;
      end
      default: state_d = ALIVE;
    endcase
    boom_d   = (state_d == BOOM) || (state_d == OVER);
    invuln_d = state_d == INVULN;
    over_d   = state_d == OVER;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= ALIVE;
      sync_q    <= 3'd0;
      px_q      <= 10'd0;
      py_q      <= 10'd0;
      cnt_q     <= 8'd0;
      lives_q   <= 3'(LIVES);
      pending_q <= 1'b0;
      boom_q    <= 1'b0;
      invuln_q  <= 1'b0;
      over_q    <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      px_q      <= x;
      py_q      <= y;
      cnt_q     <= cnt_d;
      lives_q   <= lives_d;
      pending_q <= pending_d;
      boom_q    <= boom_d;
      invuln_q  <= invuln_d;
      over_q    <= over_d;
      hit_q     <= hit;
    end
  assign boom      = boom_q;
  assign invuln    = invuln_q;
  assign game_over = over_q;
  assign lives     = lives_q;
  assign hit_pulse = hit_q;
endmodule

// File: tb/tb_plane_hit_ctrl.sv
// tb_plane_hit_ctrl: directed and randomized frame/tick scenarios checked against an event-level model
module tb_plane_hit_ctrl;
  localparam int NL = 3, HOLD = 32, INV = 64;
  logic       clk = 0, rst = 1, clk_move = 0, restart = 0;
  logic [9:0] x = 0, y = 0;
  logic       myplane_en = 0, enemy_en = 0, ebullet_en = 0, myplane_exist = 1;
  logic       boom, invuln, game_over, hit_pulse;
  logic [2:0] lives;
  int total = 0, bad = 0, hits = 0;
  int m_lives, m_phase, m_cnt;
  logic [5:0] obs;
  assign obs = {lives, boom, invuln, game_over};
  plane_hit_ctrl #(.LIVES(NL), .BOOM_HOLD(HOLD), .INVULN_TICKS(INV), .H_ACTIVE(640), .V_ACTIVE(480)) dut (
    .clk(clk), .rst(rst), .clk_move(clk_move), .x(x), .y(y), .myplane_en(myplane_en),
    .enemy_en(enemy_en), .ebullet_en(ebullet_en), .myplane_exist(myplane_exist), .restart(restart),
    .boom(boom), .invuln(invuln), .lives(lives), .game_over(game_over), .hit_pulse(hit_pulse));
  always #5 clk = ~clk;
  always @(negedge clk) if (hit_pulse) hits++;
  task automatic pix(input int xv, input int yv, input bit me, input bit en, input bit eb);
    @(negedge clk);
    x = 10'(xv); y = 10'(yv); myplane_en = me; enemy_en = en; ebullet_en = eb;
  endtask
  task automatic move_tick();
    pix(0, 0, 0, 0, 0);
    clk_move = 1;
    repeat (4) pix(0, 0, 0, 0, 0);
    clk_move = 0;
    repeat (4) pix(0, 0, 0, 0, 0);
  endtask
  task automatic ticks(input int n);
    repeat (n) move_tick();
  endtask
  task automatic end_frame(input int hold, input bit me, input bit en, input bit eb);
    repeat (hold) pix(639, 479, me, en, eb);
    repeat (3) pix(0, 0, 0, 0, 0);
  endtask
  task automatic do_restart();
    @(negedge clk); restart = 1;
    @(negedge clk); restart = 0;
    @(negedge clk);
  endtask
  task automatic model_frame(input bit ov, input bit ex, output bit h);
    h = (m_phase == 0) && ov && ex;
    if (h) begin m_lives--; m_phase = 1; m_cnt = 0; end
  endtask
  task automatic model_tick();
    if (m_phase == 1) begin
      m_cnt++;
      if (m_cnt == HOLD) begin m_cnt = 0; m_phase = (m_lives == 0) ? 3 : 2; end
    end else if (m_phase == 2) begin
      m_cnt++;
      if (m_cnt == INV) begin m_cnt = 0; m_phase = 0; end
    end
  endtask
  function automatic logic [5:0] model_obs();
    return {3'(m_lives), (m_phase == 1) || (m_phase == 3), m_phase == 2, m_phase == 3};
  endfunction
  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    total++; if (obs !== {3'd3, 3'b000}) begin bad++; $display("FAIL reset obs=%b want %b", obs, {3'd3, 3'b000}); end
    total++; if (hit_pulse !== 1'b0) begin bad++; $display("FAIL reset hit_pulse=%b want 0", hit_pulse); end
    rst = 0;
    @(negedge clk);
  endtask
  task automatic test_single_hit();
    int h0 = hits;
    for (int i = 0; i < 5; i++) pix(300 + i, 440, 1, 1, 0);
    pix(639, 479, 0, 0, 0);
    pix(0, 0, 0, 0, 0);
    total++; if (hit_pulse !== 1'b1) begin bad++; $display("FAIL hit_latency hit_pulse=%b want 1", hit_pulse); end
    total++; if (obs !== {3'd2, 3'b100}) begin bad++; $display("FAIL hit_state obs=%b want %b", obs, {3'd2, 3'b100}); end
    pix(0, 0, 0, 0, 0);
    total++; if (hit_pulse !== 1'b0) begin bad++; $display("FAIL hit_one_cycle hit_pulse=%b want 0", hit_pulse); end
    total++; if (hits - h0 !== 1) begin bad++; $display("FAIL hit_count got=%0d want 1", hits - h0); end
    ticks(10);
    h0 = hits;
    pix(300, 440, 1, 0, 1); end_frame(1, 0, 0, 0);
    total++; if (hits - h0 !== 0) begin bad++; $display("FAIL immune_boom hits=%0d want 0", hits - h0); end
    ticks(21);
    total++; if (obs !== {3'd2, 3'b100}) begin bad++; $display("FAIL boom_hold31 obs=%b want %b", obs, {3'd2, 3'b100}); end
    ticks(1);
    total++; if (obs !== {3'd2, 3'b010}) begin bad++; $display("FAIL boom_end obs=%b want %b", obs, {3'd2, 3'b010}); end
    h0 = hits;
    pix(10, 10, 1, 1, 1); end_frame(2, 1, 1, 0);
    total++; if (hits - h0 !== 0) begin bad++; $display("FAIL immune_inv hits=%0d want 0", hits - h0); end
    ticks(63);
    total++; if (obs !== {3'd2, 3'b010}) begin bad++; $display("FAIL inv_hold63 obs=%b want %b", obs, {3'd2, 3'b010}); end
    ticks(1);
    total++; if (obs !== {3'd2, 3'b000}) begin bad++; $display("FAIL inv_end obs=%b want %b", obs, {3'd2, 3'b000}); end
  endtask
  task automatic test_one_per_frame();
    int h0 = hits;
    pix(100, 50, 1, 1, 0); pix(200, 300, 1, 0, 1); pix(500, 470, 1, 1, 1);
    end_frame(1, 0, 0, 0);
    total++; if (hits - h0 !== 1) begin bad++; $display("FAIL one_per_frame hits=%0d want 1", hits - h0); end
    total++; if (lives !== 3'd1) begin bad++; $display("FAIL one_per_frame lives=%0d want 1", lives); end
    ticks(HOLD + INV);
    total++; if (obs !== {3'd1, 3'b000}) begin bad++; $display("FAIL back_alive obs=%b want %b", obs, {3'd1, 3'b000}); end
  endtask
  task automatic test_boundary();
    int h0 = hits;
    pix(640, 479, 1, 1, 0); pix(640, 100, 1, 0, 1);
    end_frame(1, 0, 0, 0);
    total++; if (hits - h0 !== 0) begin bad++; $display("FAIL x640 hits=%0d want 0", hits - h0); end
    h0 = hits;
    end_frame(4, 1, 1, 0);
    total++; if (hits - h0 !== 1) begin bad++; $display("FAIL corner_hold hits=%0d want 1", hits - h0); end
    total++; if (obs !== {3'd0, 3'b100}) begin bad++; $display("FAIL corner_hit obs=%b want %b", obs, {3'd0, 3'b100}); end
    ticks(HOLD);
    total++; if (obs !== {3'd0, 3'b101}) begin bad++; $display("FAIL game_over obs=%b want %b", obs, {3'd0, 3'b101}); end
    ticks(5);
    total++; if (obs !== {3'd0, 3'b101}) begin bad++; $display("FAIL over_stays obs=%b want %b", obs, {3'd0, 3'b101}); end
  endtask
  task automatic test_restart();
    do_restart();
    total++; if (obs !== {3'd3, 3'b000}) begin bad++; $display("FAIL restart obs=%b want %b", obs, {3'd3, 3'b000}); end
  endtask
  task automatic test_exist();
    int h0 = hits;
    myplane_exist = 0;
    pix(100, 100, 1, 1, 0); end_frame(1, 0, 0, 0);
    myplane_exist = 1;
    total++; if (hits - h0 !== 0) begin bad++; $display("FAIL no_exist hits=%0d want 0", hits - h0); end
    end_frame(1, 0, 0, 0);
    total++; if (hits - h0 !== 0) begin bad++; $display("FAIL pending_cleared hits=%0d want 0", hits - h0); end
    total++; if (lives !== 3'd3) begin bad++; $display("FAIL no_exist lives=%0d want 3", lives); end
  endtask
  task automatic test_restart_alive();
    pix(50, 50, 1, 1, 0); end_frame(1, 0, 0, 0);
    ticks(HOLD + INV);
    do_restart();
    total++; if (obs !== {3'd2, 3'b000}) begin bad++; $display("FAIL restart_alive obs=%b want %b", obs, {3'd2, 3'b000}); end
  endtask
  task automatic test_async_reset();
    pix(60, 60, 1, 0, 1); end_frame(1, 0, 0, 0);
    ticks(10);
    total++; if (obs !== {3'd1, 3'b100}) begin bad++; $display("FAIL pre_reset obs=%b want %b", obs, {3'd1, 3'b100}); end
    @(negedge clk); #2 rst = 1; #1;
    total++; if (obs !== {3'd3, 3'b000}) begin bad++; $display("FAIL async_reset obs=%b want %b", obs, {3'd3, 3'b000}); end
    @(negedge clk); rst = 0;
    @(negedge clk);
  endtask
  task automatic test_random();
    bit ov, ex, me, en, eb, h;
    int xv, yv, h0;
    m_lives = NL; m_phase = 0; m_cnt = 0;
    for (int it = 0; it < 40; it++) begin
      ov = 0;
      ex = $urandom_range(0, 7) != 0;
      myplane_exist = ex;
      h0 = hits;
      for (int i = 0; i < int'($urandom_range(3, 20)); i++) begin
        xv = $urandom_range(0, 700); yv = $urandom_range(0, 520);
        if (xv == 639 && yv == 479) yv = 0;
        me = $urandom_range(0, 3) == 0; en = $urandom_range(0, 1); eb = $urandom_range(0, 1);
        pix(xv, yv, me, en, eb);
        if (me && (en || eb) && xv < 640 && yv < 480) ov = 1;
      end
      me = $urandom_range(0, 3) == 0; en = $urandom_range(0, 1); eb = $urandom_range(0, 1);
      end_frame($urandom_range(1, 4), me, en, eb);
      if (me && (en || eb)) ov = 1;
      myplane_exist = 1;
      model_frame(ov, ex, h);
      total++; if (hits - h0 !== int'(h)) begin bad++; $display("FAIL rand_hit it=%0d hits=%0d want %0d", it, hits - h0, h); end
      total++; if (obs !== model_obs()) begin bad++; $display("FAIL rand_frame it=%0d obs=%b want %b", it, obs, model_obs()); end
      for (int k = 0; k < int'($urandom_range(0, 40)); k++) begin move_tick(); model_tick(); end
      total++; if (obs !== model_obs()) begin bad++; $display("FAIL rand_tick it=%0d obs=%b want %b", it, obs, model_obs()); end
      if ($urandom_range(0, 2) == 0) begin
        do_restart();
        if (m_phase == 3) begin m_lives = NL; m_phase = 0; m_cnt = 0; end
        total++; if (obs !== model_obs()) begin bad++; $display("FAIL rand_restart it=%0d obs=%b want %b", it, obs, model_obs()); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_single_hit();
    test_one_per_frame();
    test_boundary();
    test_restart();
    test_exist();
    test_restart_alive();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/plane_hit_ctrl.md
# plane_hit_ctrl

Player-hit controller that drives the `boom` input of the player-plane renderer and consumes its pixel-enable (`EN`) and `myplane_exist` outputs. It detects per-pixel overlap between the player plane and hostile layers during the active frame, and commits one hit per frame at frame end. It then sequences the explosion hold, life decrement, post-respawn invulnerability and game over. It sits between the sprite renderers and the top-level game/score logic.

## Interface

**Parameters**
- `LIVES`, default 3: lives loaded at reset and restart (1–7).
- `BOOM_HOLD`, default 32: `clk_move` ticks for which `boom` stays high per hit (16–255). It must be ≥16 so the renderer's explosion counter completes.
- `INVULN_TICKS`, default 64: `clk_move` ticks of collision immunity after respawn (1–255).
- `H_ACTIVE`, default 640: active pixels per line.
- `V_ACTIVE`, default 480: active lines per frame.

**Ports**
- `clk` input 1: system clock, same as the renderer `clk`.
- `rst` input 1: asynchronous, active-high reset.
- `clk_move` input 1: movement clock; synchronized internally.
- `x` input 10: current pixel column.
- `y` input 10: current pixel row.
- `myplane_en` input 1: player-plane pixel enable (renderer `EN`).
- `enemy_en` input 1: enemy-plane pixel enable, OR of all enemy sprites.
- `ebullet_en` input 1: enemy-bullet pixel enable.
- `myplane_exist` input 1: renderer's plane-present flag.
- `restart` input 1: one-`clk` pulse requesting a new game.
- `boom` output 1: held high while the player is exploding or dead.
- `invuln` output 1: high during post-respawn immunity; used for blink rendering.
- `lives` output 3: remaining lives.
- `game_over` output 1: high in the OVER state.
- `hit_pulse` output 1: one-`clk` pulse when a hit is committed; goes to sound/score logic.

## Operation

**Tick generation**
- `clk_move` passes through a 2-flop synchronizer into `clk`.
- `tick` is a one-`clk` pulse on each synchronized rising edge.
- All hold and invulnerability counters advance only on `tick`.

**Overlap capture**
- `overlap = myplane_en & (enemy_en | ebullet_en)`, qualified by `x < H_ACTIVE` and `y < V_ACTIVE`.
- Any overlap sets sticky flag `pending`.

**Frame end**
- `frame_end` is a one-`clk` pulse on the first `clk` cycle in which (`x == H_ACTIVE-1` && `y == V_ACTIVE-1`).
- Detection compares against the registered previous (x, y), so a pixel held for multiple `clk` cycles yields one pulse.
- On `frame_end`, `pending` is evaluated and then cleared, in every state.
- Overlap present on the frame-end cycle itself counts toward that frame.

**State machine: ALIVE, BOOM, INVULN, OVER**
- **ALIVE:**
  - Condition: `frame_end` with (`pending` | `overlap`) and `myplane_exist == 1`.
  - Action: `lives <= lives - 1`, `hit_pulse` fires, counter is cleared, go to BOOM.
- **BOOM:**
  - `boom = 1`; counter increments on `tick`.
  - When the counter reaches `BOOM_HOLD` on a tick:
    - if `lives == 0`, go to OVER;
    - otherwise clear the counter and go to INVULN.
- **INVULN:**
  - `boom = 0`, `invuln = 1`; collisions are ignored.
  - Counter increments on `tick`; at `INVULN_TICKS`, go to ALIVE.
- **OVER:**
  - `boom = 1` (holds the renderer's counter saturated, so the plane stays hidden) and `game_over = 1`.
  - `restart` causes `lives <= LIVES`, clears the counter and goes to ALIVE.
- `restart` in any state other than OVER is ignored.

**Output and width rules**
- `boom`, `invuln` and `game_over` are registered decodes of the state.
- `lives` never wraps: a decrement is only possible in ALIVE, where `lives ≥ 1` holds.
- The counter is 8 bits and is compared with `==`.

## Timing

- Reset values:
  - state ALIVE;
  - `lives = LIVES`;
  - `boom = invuln = game_over = hit_pulse = 0`;
  - `pending = 0`;
  - counter = 0;
  - synchronizer flops = 0.
- Hit latency: with `frame_end` in cycle N, the state changes at edge N+1. `boom`, `hit_pulse` and the new `lives` are visible in cycle N+1.
- `boom` stays high for exactly `BOOM_HOLD` ticks: it rises at N+1 and falls one `clk` after the `BOOM_HOLD`-th tick.
- `tick` lags the `clk_move` edge by 2–3 `clk` cycles.
- Simultaneous events: `tick` and `frame_end` in the same cycle are both honoured. A collision in the same cycle as the INVULN→ALIVE transition is not counted.
- Reset mid-BOOM: returns to ALIVE with full lives and `boom = 0`, asynchronously.

## Test plan

- **Single hit:** LIVES=3; overlap for 5 pixels at (300,440) in frame 1.
  - `hit_pulse` one cycle after frame end.
  - `lives` = 2.
  - `boom` high for 32 ticks, then `invuln` high for 64 ticks, then ALIVE.
- **One hit per frame:** overlap in 3 separate places within one frame → exactly one `hit_pulse` and `lives` decrements by 1.
- **Immunity:** overlap every frame during BOOM and INVULN → no further decrement. The first overlap after returning to ALIVE → `lives` = 1.
- **Game over and restart:**
  - LIVES=1; hit → after 32 ticks `game_over = 1` and `boom` stays 1.
  - `restart` → `lives = 1`, `boom = 0`, ALIVE.
  - `restart` while ALIVE → no change.
- **Boundary:** overlap only on pixel (639,479) with (x, y) held for 4 `clk` cycles → exactly one `frame_end`, hit committed. Overlap at x=640 → ignored.
- **Async reset during BOOM tick 10** → all outputs return to reset values immediately. `myplane_exist = 0` at frame end with `pending` set → no hit.
